psram_burst_responder: RTL and testbench
========================================

Name: psram_burst_responder

Overview:
Synthesizable cycle-accurate model of the PSRAM device side of the burst interface driven by psram_burst_controller. It decodes CE#/ADV#/WE#/OE#, latches the burst start address, waits a fixed initial latency, then absorbs write words or supplies read words from an internal array, advancing the address each clock. It is used in benches and on-FPGA loopback in place of the physical chip. psram_clk is a forwarded copy of clk_i, so the block runs on clk_i only.

Parameters:
ADDR_BITS, 8, internal array address width; depth 2**ADDR_BITS words; psram_adr upper bits ignored
LATENCY, 3, clocks from address cycle to first data word; legal 1..15
WRAP_EN, 1, 1: pointer wraps at array end; 0: pointer saturates at last word and err_o sets

Ports:
clk_i  in  1  system clock (same as psram_clk)
rst_i  in  1  synchronous reset, active-high
psram_adr  in  23  burst start address, valid when adv_n low
psram_dat_i  in  16  write data from controller
psram_dat_o  out  16  read data to controller
psram_dat_oe  out  1  read-data drive enable (tristate control for top level)
psram_we_n  in  1  write enable, sampled at address cycle
psram_ce_n  in  1  chip enable, active low
psram_adv_n  in  1  address valid, active low
psram_oe_n  in  1  output enable, active low
psram_wait  out  1  high while initial latency elapses (data not yet valid)
burst_cnt_o  out  8  words moved in current/last burst, saturating at 255
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (sync, rst_i high at clk_i edge): state IDLE; psram_dat_o=0, psram_dat_oe=0, psram_wait=0, burst_cnt_o=0, err_o=0; array contents not reset. Reset mid-burst aborts immediately, no further array write.
- States: IDLE, LAT, WRITE, READ.
- IDLE: ce_n=0 & adv_n=0 at edge -> latch ptr=psram_adr[ADDR_BITS-1:0], dir=~we_n, lat_cnt=LATENCY-1, burst_cnt_o=0; if LATENCY=1 go directly to WRITE/READ, else LAT with psram_wait=1.
- Address cycle = cycle 0; word k is transferred in cycle LATENCY+k.
- LAT: lat_cnt decrements each clock; leaving LAT when lat_cnt=1 -> WRITE or READ per dir; psram_wait drops to 0 the same edge. For READ, psram_dat_o <= mem[ptr] registered on that edge so data is valid in cycle LATENCY.
- WRITE: each clock with ce_n=0: mem[ptr] <= psram_dat_i, ptr++, burst_cnt_o++.
- READ: each clock with ce_n=0: ptr++, psram_dat_o <= mem[ptr+1] (prefetch next), burst_cnt_o++. psram_dat_oe = registered (~oe_n & ~ce_n & state==READ); 0 in all other states.
- ce_n=1 in LAT/WRITE/READ -> IDLE next edge, psram_wait=0, psram_dat_oe=0; no transfer on that cycle. burst_cnt_o holds.
- adv_n=0 with ce_n=0 while in LAT/WRITE/READ: restart; treated as new address cycle (re-latch, reload latency), current word not transferred.
- Pointer at 2**ADDR_BITS-1: WRAP_EN=1 -> 0; WRAP_EN=0 -> hold, set err_o.
- err_o sets (sticky until reset) on: we_n changing during WRITE/READ; oe_n=0 during WRITE; pointer saturation.
- burst_cnt_o saturates at 255.

Decomposition:
- Package psram_pkg: state encoding constants, PSRAM_ADR_W=23, PSRAM_DAT_W=16, default LATENCY; shared with psram_burst_controller.
- Sub-module psram_mem_array: single-port synchronous RAM, 2**ADDR_BITS x 16, registered read, write-enable; responder holds FSM, pointer and counters.

Test Plan:
- Reset: rst_i=1 one clock while ce_n=0, adv_n=0 -> state IDLE, all outputs 0, no array write.
- Write burst: adv_n=0, ce_n=0, we_n=0, adr=0x12D687, then data 0x0059,0x0001..0x0004, LATENCY=3 -> psram_wait=1 cycles 1-2; mem[0x87..0x8B]=0x0059,1,2,3,4; burst_cnt_o=5.
- Read-back: read burst adr=0x12D687, oe_n=0 -> psram_dat_oe=1 from cycle 3, psram_dat_o=0x0059,1,2,3,4 on cycles 3..7.
- Wrap: ADDR_BITS=8, write 3 words from adr 0xFE, WRAP_EN=1 -> mem[0xFE]=w0, mem[0xFF]=w1, mem[0x00]=w2, err_o=0; WRAP_EN=0 -> third word to 0xFF, err_o=1.
- Abort/restart: ce_n=1 in cycle 2 (LAT) -> IDLE, psram_wait=0, no write; adv_n=0 mid-write at adr 0x10 -> latency reloads, next words land at 0x10.
- Protocol error: toggle we_n during WRITE -> err_o=1 and stays 1 across later clean bursts until rst_i.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared PSRAM burst-interface definitions.
// Used by both the controller and the device-side responder.
package psram_pkg;

    localparam int PSRAM_ADR_W       = 23;
    localparam int PSRAM_DAT_W       = 16;
    localparam int PSRAM_LATENCY_DEF = 3;
    localparam int PSRAM_LAT_W       = 4;
    localparam int PSRAM_CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAT   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } psram_state_e;

    function automatic logic [PSRAM_CNT_W-1:0] sat_inc(
        input logic [PSRAM_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + PSRAM_CNT_W'(1);
    endfunction

endpackage

// File: rtl/psram_burst_responder_mem_array.sv
// Single-port synchronous RAM with registered read.
// Only the read register is reset; array contents survive reset.
module psram_mem_array
    import psram_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic [ADDR_BITS-1:0]   addr_i,
    input  logic [PSRAM_DAT_W-1:0] wdata_i,
    output logic [PSRAM_DAT_W-1:0] rdata_o
);

    logic [PSRAM_DAT_W-1:0] mem_q [2**ADDR_BITS];
    logic [PSRAM_DAT_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/psram_burst_responder.sv
// Device-side PSRAM burst model: decodes CE#/ADV#/WE#/OE#,
// waits the initial latency, then streams words to/from the array.
module psram_burst_responder
    import psram_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = PSRAM_LATENCY_DEF,
    parameter bit WRAP_EN   = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [PSRAM_ADR_W-1:0] psram_adr,
    input  logic [PSRAM_DAT_W-1:0] psram_dat_i,
    output logic [PSRAM_DAT_W-1:0] psram_dat_o,
    output logic                   psram_dat_oe,
    input  logic                   psram_we_n,
    input  logic                   psram_ce_n,
    input  logic                   psram_adv_n,
    input  logic                   psram_oe_n,
    output logic                   psram_wait,
    output logic [PSRAM_CNT_W-1:0] burst_cnt_o,
    output logic                   err_o
);

    localparam logic [ADDR_BITS-1:0]   PTR_MAX  = '1;
    localparam logic [PSRAM_LAT_W-1:0] LAT_INIT = PSRAM_LAT_W'(LATENCY - 1);

    psram_state_e             state_q, state_d;
    logic [ADDR_BITS-1:0]     ptr_q, ptr_d;
    logic                     dir_q, dir_d;
    logic [PSRAM_LAT_W-1:0]   lat_q, lat_d;
    logic [PSRAM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     wait_q, wait_d;
    logic                     oe_q, oe_d;

    logic                     start;
    logic                     xfer;
    logic                     mem_we;
    logic                     mem_re;
    logic [ADDR_BITS-1:0]     mem_addr;

    logic                     unused_adr_hi;
    assign unused_adr_hi = ^psram_adr[PSRAM_ADR_W-1:ADDR_BITS];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        start   = 1'b0;
        xfer    = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!psram_ce_n && !psram_adv_n) begin
                    start = 1'b1;
                end
            end
            ST_LAT: begin
                if (psram_ce_n) begin
                    state_d = ST_IDLE;
                end else if (!psram_adv_n) begin
                    start = 1'b1;
                end else if (lat_q == PSRAM_LAT_W'(1)) begin
                    state_d = dir_q ? ST_WRITE : ST_READ;
                    mem_re  = ~dir_q;
                end else begin
                    lat_d = lat_q - PSRAM_LAT_W'(1);
                end
            end
            ST_WRITE: begin
                if (psram_ce_n) begin
                    state_d = ST_IDLE;
                end else if (!psram_adv_n) begin
                    start = 1'b1;
                end else begin
                    xfer   = 1'b1;
                    mem_we = 1'b1;
                    if (psram_we_n || !psram_oe_n) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (psram_ce_n) begin
                    state_d = ST_IDLE;
                end else if (!psram_adv_n) begin
                    start = 1'b1;
                end else begin
                    xfer   = 1'b1;
                    mem_re = 1'b1;
                    if (!psram_we_n) begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase

        // A new address cycle in any state re-latches and reloads latency.
        if (start) begin
            ptr_d = psram_adr[ADDR_BITS-1:0];
            dir_d = ~psram_we_n;
            lat_d = LAT_INIT;
            cnt_d = '0;
            if (LATENCY == 1) begin
                state_d = psram_we_n ? ST_READ : ST_WRITE;
                mem_re  = psram_we_n;
            end else begin
                state_d = ST_LAT;
            end
        end

        if (xfer) begin
            cnt_d = sat_inc(cnt_q);
            if (ptr_q != PTR_MAX) begin
                ptr_d = ptr_q + ADDR_BITS'(1);
            end else if (WRAP_EN) begin
                ptr_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end

        wait_d = (state_d == ST_LAT);
        oe_d   = (state_d == ST_READ) & ~psram_oe_n & ~psram_ce_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            dir_q   <= 1'b0;
            lat_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wait_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            oe_q    <= oe_d;
        end
    end

    // Writes use the current pointer; reads prefetch at the next one.
    assign mem_addr = mem_we ? ptr_q : ptr_d;

    psram_mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_mem (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (mem_we & ~rst_i),
        .re_i   (mem_re),
        .addr_i (mem_addr),
        .wdata_i(psram_dat_i),
        .rdata_o(psram_dat_o)
    );

    assign psram_dat_oe = oe_q;
    assign psram_wait   = wait_q;
    assign burst_cnt_o  = cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_psram_burst_responder.sv
// Directed bench for psram_burst_responder (LATENCY=3),
// with a wrapping and a saturating instance on shared inputs.
module tb_psram_burst_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] adr;
    logic [15:0] dat_i;
    logic        we_n, ce_n, adv_n, oe_n;

    logic [15:0] dat_o, dat_o_nw;
    logic        doe, doe_nw;
    logic        wt, wt_nw;
    logic [7:0]  cnt, cnt_nw;
    logic        err, err_nw;

    int checks = 0;
    int failures = 0;

    logic [15:0] wbuf [8];

    always #5 clk = ~clk;

    psram_burst_responder #(
        .ADDR_BITS(8), .LATENCY(3), .WRAP_EN(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .psram_adr(adr),
        .psram_dat_i(dat_i), .psram_dat_o(dat_o),
        .psram_dat_oe(doe), .psram_we_n(we_n),
        .psram_ce_n(ce_n), .psram_adv_n(adv_n),
        .psram_oe_n(oe_n), .psram_wait(wt),
        .burst_cnt_o(cnt), .err_o(err)
    );

    psram_burst_responder #(
        .ADDR_BITS(8), .LATENCY(3), .WRAP_EN(1'b0)
    ) dut_nw (
        .clk_i(clk), .rst_i(rst), .psram_adr(adr),
        .psram_dat_i(dat_i), .psram_dat_o(dat_o_nw),
        .psram_dat_oe(doe_nw), .psram_we_n(we_n),
        .psram_ce_n(ce_n), .psram_adv_n(adv_n),
        .psram_oe_n(oe_n), .psram_wait(wt_nw),
        .burst_cnt_o(cnt_nw), .err_o(err_nw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic end_burst();
        ce_n = 1'b1; adv_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic wr_burst(input logic [22:0] a, input int n);
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; adr = a;
        tick();
        adv_n = 1'b1;
        tick();
        tick();
        for (int k = 0; k < n; k++) begin
            dat_i = wbuf[k];
            tick();
        end
        end_burst();
    endtask

    // Leaves the bench at cycle 3 with the first read word on the bus.
    task automatic rd_begin(input logic [22:0] a);
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; adr = a;
        tick();
        adv_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0;
        oe_n = 1'b1; adr = 23'h33; dat_i = 16'h7777;
        tick();
        rst = 1'b0; ce_n = 1'b1; adv_n = 1'b1; we_n = 1'b1;
        checks++;
        if ({wt, doe, dat_o, cnt, err} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got wait=%b oe=%b dat=%h cnt=%0d err=%b want all 0",
                     wt, doe, dat_o, cnt, err);
        end
        checks++;
        if ({wt_nw, doe_nw, dat_o_nw, cnt_nw, err_nw} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs_nw: got nonzero outputs want all 0");
        end
        tick();
    endtask

    task automatic test_write();
        wbuf[0] = 16'h0059; wbuf[1] = 16'h0001; wbuf[2] = 16'h0002;
        wbuf[3] = 16'h0003; wbuf[4] = 16'h0004;
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; adr = 23'h12D687;
        tick();
        adv_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (wt !== 1'b1) begin
                failures++;
                $display("FAIL write_wait_c%0d: got %b want 1", c, wt);
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                checks++;
                if (wt !== 1'b0) begin
                    failures++;
                    $display("FAIL write_wait_c3: got %b want 0", wt);
                end
            end
            dat_i = wbuf[k];
            tick();
        end
        ce_n = 1'b1;
        checks++;
        if (cnt !== 8'd5) begin
            failures++;
            $display("FAIL write_cnt: got %0d want 5", cnt);
        end
        tick();
        tick();
        checks++;
        if (cnt !== 8'd5 || wt !== 1'b0) begin
            failures++;
            $display("FAIL write_cnt_hold: got cnt=%0d wait=%b want 5 0", cnt, wt);
        end
        end_burst();
    endtask

    task automatic test_readback();
        logic [15:0] exp [5];
        exp = '{16'h0059, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; adr = 23'h12D687;
        tick();
        adv_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (doe !== 1'b0 || wt !== 1'b1) begin
                failures++;
                $display("FAIL read_lat_c%0d: got oe=%b wait=%b want 0 1", c, doe, wt);
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (doe !== 1'b1 || dat_o !== exp[k]) begin
                failures++;
                $display("FAIL read_word%0d: got oe=%b dat=%h want 1 %h", k, doe, dat_o, exp[k]);
            end
            tick();
        end
        ce_n = 1'b1; oe_n = 1'b1;
        tick();
        checks++;
        if (doe !== 1'b0 || cnt !== 8'd5) begin
            failures++;
            $display("FAIL read_end: got oe=%b cnt=%0d want 0 5", doe, cnt);
        end
        end_burst();
    endtask

    task automatic test_wrap();
        logic [15:0] e_w  [3];
        logic [15:0] e_nw [3];
        e_w  = '{16'hA001, 16'hA002, 16'hA003};
        e_nw = '{16'hA001, 16'hA003, 16'hA003};
        wbuf[0] = 16'hA001; wbuf[1] = 16'hA002; wbuf[2] = 16'hA003;
        wr_burst(23'h7FFFFE, 3);
        checks++;
        if (err !== 1'b0 || err_nw !== 1'b1) begin
            failures++;
            $display("FAIL wrap_err: got wrap=%b sat=%b want 0 1", err, err_nw);
        end
        rd_begin(23'h7FFFFE);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dat_o !== e_w[k] || dat_o_nw !== e_nw[k]) begin
                failures++;
                $display("FAIL wrap_read%0d: got %h/%h want %h/%h",
                         k, dat_o, dat_o_nw, e_w[k], e_nw[k]);
            end
            tick();
        end
        end_burst();
    endtask

    task automatic test_reset_midburst();
        wbuf[0] = 16'h1111;
        wr_burst(23'h30, 1);
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; adr = 23'h30;
        tick();
        adv_n = 1'b1;
        tick();
        tick();
        dat_i = 16'hDEAD; rst = 1'b1;
        tick();
        rst = 1'b0; ce_n = 1'b1;
        checks++;
        if (wt !== 1'b0 || cnt !== 8'd0 || err !== 1'b0 || err_nw !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: got wait=%b cnt=%0d err=%b/%b want 0 0 0/0",
                     wt, cnt, err, err_nw);
        end
        tick();
        rd_begin(23'h30);
        checks++;
        if (dat_o !== 16'h1111) begin
            failures++;
            $display("FAIL midreset_nowrite: got %h want 1111", dat_o);
        end
        tick();
        end_burst();
    endtask

    task automatic test_abort();
        wbuf[0] = 16'h4444;
        wr_burst(23'h40, 1);
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; adr = 23'h40;
        tick();
        adv_n = 1'b1;
        tick();
        ce_n = 1'b1; dat_i = 16'hBEEF;
        tick();
        checks++;
        if (wt !== 1'b0 || cnt !== 8'd0) begin
            failures++;
            $display("FAIL abort_idle: got wait=%b cnt=%0d want 0 0", wt, cnt);
        end
        tick();
        tick();
        rd_begin(23'h40);
        checks++;
        if (dat_o !== 16'h4444) begin
            failures++;
            $display("FAIL abort_nowrite: got %h want 4444", dat_o);
        end
        tick();
        end_burst();
    endtask

    task automatic test_restart();
        logic [15:0] e10 [2];
        logic [15:0] e50 [2];
        e10 = '{16'h1000, 16'h1001};
        e50 = '{16'h5000, 16'h5001};
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; adr = 23'h50;
        tick();
        adv_n = 1'b1;
        tick();
        tick();
        dat_i = 16'h5000;
        tick();
        dat_i = 16'h5001;
        tick();
        adv_n = 1'b0; adr = 23'h10; dat_i = 16'h0BAD;
        tick();
        adv_n = 1'b1;
        for (int c = 6; c <= 7; c++) begin
            checks++;
            if (wt !== 1'b1) begin
                failures++;
                $display("FAIL restart_wait_c%0d: got %b want 1", c, wt);
            end
            tick();
        end
        dat_i = 16'h1000;
        tick();
        dat_i = 16'h1001;
        tick();
        ce_n = 1'b1;
        checks++;
        if (cnt !== 8'd2) begin
            failures++;
            $display("FAIL restart_cnt: got %0d want 2", cnt);
        end
        end_burst();
        rd_begin(23'h10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dat_o !== e10[k]) begin
                failures++;
                $display("FAIL restart_new%0d: got %h want %h", k, dat_o, e10[k]);
            end
            tick();
        end
        end_burst();
        rd_begin(23'h50);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dat_o !== e50[k]) begin
                failures++;
                $display("FAIL restart_old%0d: got %h want %h", k, dat_o, e50[k]);
            end
            tick();
        end
        end_burst();
    endtask

    task automatic test_protocol();
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; adr = 23'h60;
        tick();
        adv_n = 1'b1;
        tick();
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL proto_pre: got %b want 0", err);
        end
        dat_i = 16'h6000;
        tick();
        we_n = 1'b1; dat_i = 16'h6001;
        tick();
        we_n = 1'b0;
        checks++;
        if (err !== 1'b1 || err_nw !== 1'b1) begin
            failures++;
            $display("FAIL proto_set: got %b/%b want 1/1", err, err_nw);
        end
        end_burst();
        rd_begin(23'h60);
        checks++;
        if (dat_o !== 16'h6000) begin
            failures++;
            $display("FAIL proto_read: got %h want 6000", dat_o);
        end
        tick();
        end_burst();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL proto_sticky: got %b want 1", err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (err !== 1'b0 || err_nw !== 1'b0) begin
            failures++;
            $display("FAIL proto_clear: got %b/%b want 0/0", err, err_nw);
        end
    endtask

    initial begin
        rst = 1'b1; adr = '0; dat_i = '0;
        we_n = 1'b1; ce_n = 1'b1; adv_n = 1'b1; oe_n = 1'b1;
        tick();
        tick();
        test_reset();
        test_write();
        test_readback();
        test_wrap();
        test_reset_midburst();
        test_abort();
        test_restart();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
